// File: rtl/wt_mem_req_arbiter.sv
// Three-way memory request arbiter (icache fill, dcache load miss, write-buffer store) with
// TID allocation, response routing and store throttling. Optional macro: CVA6_MEMARB_WBUF_URGENT_EN.
module wt_mem_req_arbiter #(
   parameter int unsigned MEM_TID_WIDTH          = 2,
   parameter int unsigned MAX_OUTSTANDING_STORES = 7,
   parameter int unsigned ADDR_WIDTH             = 64,
   parameter int unsigned DATA_WIDTH             = 64
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic [2:0]                                    req_valid_i,
   output logic [2:0]                                    req_ready_o,
   input  logic [3*ADDR_WIDTH-1:0]                       req_addr_i,
   input  logic [DATA_WIDTH-1:0]                         req_wdata_i,
   input  logic                                          wbuf_full_i,
   output logic                                          mem_req_valid_o,
   input  logic                                          mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]                         mem_req_addr_o,
   output logic [DATA_WIDTH-1:0]                         mem_req_wdata_o,
   output logic                                          mem_req_we_o,
   output logic [MEM_TID_WIDTH-1:0]                      mem_req_tid_o,
   input  logic                                          mem_rsp_valid_i,
   input  logic [MEM_TID_WIDTH-1:0]                      mem_rsp_tid_i,
   output logic [2:0]                                    rsp_valid_o,
   output logic                                          rsp_err_o,
   output logic [$clog2(MAX_OUTSTANDING_STORES+1)-1:0]   st_cnt_o,
   output logic                                          idle_o
);

   localparam int unsigned NTID = 2**MEM_TID_WIDTH;
   localparam int unsigned SCW  = $clog2(MAX_OUTSTANDING_STORES+1);

   logic [NTID-1:0]          busy_q, busy_d;
   logic [1:0]               owner_q [NTID];
   logic [1:0]               rr_q, rr_d;
   logic                     mvld_q, mvld_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic                     we_q, we_d;
   logic [MEM_TID_WIDTH-1:0] tid_q, tid_d;
   logic [SCW-1:0]           st_cnt_q, st_cnt_d;

   logic                     tid_avail, st_room, slot_free, capture;
   logic [MEM_TID_WIDTH-1:0] free_tid;
   logic [2:0]               elig;
   logic [1:0]               winner, cand;
   logic [2:0]               cand_w;
   logic                     win_found, urgent_win;
   logic                     rsp_busy, rsp_hit, st_inc, st_dec;
   logic [1:0]               rsp_owner;
   logic [ADDR_WIDTH-1:0]    win_addr;

   // Lowest-index free TID; only registered state counts, so a TID freed this cycle is not reused yet.
   always_comb begin
      free_tid = '0;
      for (int i = int'(NTID) - 1; i >= 0; i--) begin
         if (!busy_q[i]) free_tid = MEM_TID_WIDTH'(i);
      end
   end

   assign tid_avail = ~&busy_q;
   assign st_room   = st_cnt_q < SCW'(MAX_OUTSTANDING_STORES);
   assign elig      = req_valid_i & {st_room, 2'b11} & {3{tid_avail}};
   assign slot_free = !mvld_q || mem_req_ready_i;

   always_comb begin
      win_found  = 1'b0;
      winner     = 2'd0;
      urgent_win = 1'b0;
      cand       = 2'd0;
      cand_w     = 3'd0;
      for (int i = 0; i < 3; i++) begin
         cand_w = {1'b0, rr_q} + 3'(i);
         if (cand_w >= 3'd3) cand_w = cand_w - 3'd3;
         cand = cand_w[1:0];
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            winner    = cand;
         end
      end
`ifdef CVA6_MEMARB_WBUF_URGENT_EN
      // A full write buffer jumps the queue without disturbing the round-robin order.
      if (wbuf_full_i && elig[2]) begin
         win_found  = 1'b1;
         winner     = 2'd2;
         urgent_win = 1'b1;
      end
`endif
   end

`ifndef CVA6_MEMARB_WBUF_URGENT_EN
   logic unused_wbuf;
   assign unused_wbuf = wbuf_full_i;
`endif

   always_comb begin
      case (winner)
         2'd1:    win_addr = req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
         2'd2:    win_addr = req_addr_i[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
         default: win_addr = req_addr_i[ADDR_WIDTH-1:0];
      endcase
   end

   // Combinational outputs are gated by reset so they drop without a clock edge.
   assign capture     = rst_ni && slot_free && win_found;
   assign req_ready_o = capture ? (3'b001 << winner) : 3'b000;

   assign rsp_busy    = busy_q[mem_rsp_tid_i];
   assign rsp_owner   = owner_q[mem_rsp_tid_i];
   assign rsp_hit     = rst_ni && mem_rsp_valid_i && rsp_busy;
   assign rsp_err_o   = rst_ni && mem_rsp_valid_i && !rsp_busy;
   assign rsp_valid_o = rsp_hit ? (3'b001 << rsp_owner) : 3'b000;

   assign st_inc = capture && (winner == 2'd2);
   assign st_dec = rsp_hit && (rsp_owner == 2'd2);

   always_comb begin
      busy_d   = busy_q;
      rr_d     = rr_q;
      mvld_d   = mvld_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      tid_d    = tid_q;
      st_cnt_d = st_cnt_q;
      if (rsp_hit) busy_d[mem_rsp_tid_i] = 1'b0;
      if (capture) begin
         busy_d[free_tid] = 1'b1;
         mvld_d  = 1'b1;
         addr_d  = win_addr;
         wdata_d = req_wdata_i;
         we_d    = (winner == 2'd2);
         tid_d   = free_tid;
         if (!urgent_win) rr_d = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
      end else if (mem_req_ready_i) begin
         mvld_d = 1'b0;
      end
      if (st_inc && !st_dec)      st_cnt_d = st_cnt_q + SCW'(1);
      else if (st_dec && !st_inc) st_cnt_d = st_cnt_q - SCW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q   <= '0;
         rr_q     <= 2'd0;
         mvld_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         tid_q    <= '0;
         st_cnt_q <= '0;
      end else begin
         busy_q   <= busy_d;
         rr_q     <= rr_d;
         mvld_q   <= mvld_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         tid_q    <= tid_d;
         st_cnt_q <= st_cnt_d;
      end
   end

   // Owner entries are only read for allocated TIDs, so they need no reset.
   always_ff @(posedge clk_i) begin
      if (capture) owner_q[free_tid] <= winner;
   end

   assign mem_req_valid_o = mvld_q;
   assign mem_req_addr_o  = addr_q;
   assign mem_req_wdata_o = wdata_q;
   assign mem_req_we_o    = we_q;
   assign mem_req_tid_o   = tid_q;
   assign st_cnt_o        = st_cnt_q;
   assign idle_o          = ~|busy_q && !mvld_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Scoreboard bench for wt_mem_req_arbiter: directed stimulus pushes expected memory requests and
// responses; a negedge monitor pops and compares. Built with 8 TIDs so seven stores can be in flight.
module tb_wt_mem_req_arbiter;
   localparam int TW = 3;

   logic           clk, rst_n;
   logic [2:0]     req_valid, req_ready;
   logic [191:0]   req_addr;
   logic [63:0]    req_wdata;
   logic           wbuf_full;
   logic           mem_req_valid, mem_req_ready, mem_req_we;
   logic [63:0]    mem_req_addr, mem_req_wdata;
   logic [TW-1:0]  mem_req_tid;
   logic           mem_rsp_valid;
   logic [TW-1:0]  mem_rsp_tid;
   logic [2:0]     rsp_valid;
   logic           rsp_err;
   logic [2:0]     st_cnt;
   logic           idle;

   wt_mem_req_arbiter #(.MEM_TID_WIDTH(TW), .MAX_OUTSTANDING_STORES(7), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .wbuf_full_i(wbuf_full),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
      .mem_req_wdata_o(mem_req_wdata), .mem_req_we_o(mem_req_we), .mem_req_tid_o(mem_req_tid),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_tid_i(mem_rsp_tid), .rsp_valid_o(rsp_valid),
      .rsp_err_o(rsp_err), .st_cnt_o(st_cnt), .idle_o(idle));

   typedef struct packed {
      logic [63:0]   addr;
      logic [63:0]   wdata;
      logic          we;
      logic [TW-1:0] tid;
   } req_t;
   typedef struct packed {
      logic [2:0] vld;
      logic       err;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Requester k always presents address 0x1000*(k+1).
   task automatic exp_req(input int k, input int tid, input logic [63:0] wd);
      req_t r;
      r.addr  = 64'h1000 * (k + 1);
      r.wdata = wd;
      r.we    = (k == 2);
      r.tid   = TW'(tid);
      req_q.push_back(r);
   endtask

   task automatic step(input logic [2:0] exp_rdy);
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      @(posedge clk); #1;
   endtask

   task automatic rsp(input int tid, input logic [2:0] vld, input logic err);
      rsp_t r;
      r.vld = vld;
      r.err = err;
      rsp_q.push_back(r);
      mem_rsp_valid = 1'b1;
      mem_rsp_tid   = TW'(tid);
      @(negedge clk);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req_valid && mem_req_ready) begin
            if (req_q.size() == 0) chk("unexpected_req", 64'(mem_req_tid), 64'hdead);
            else begin
               req_t r;
               r = req_q.pop_front();
               chk("req_addr", mem_req_addr, r.addr);
               chk("req_we", 64'(mem_req_we), 64'(r.we));
               chk("req_tid", 64'(mem_req_tid), 64'(r.tid));
               if (r.we) chk("req_wdata", mem_req_wdata, r.wdata);
            end
         end
         if (mem_rsp_valid) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(mem_rsp_tid), 64'hdead);
            else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("rsp_valid", 64'(rsp_valid), 64'(r.vld));
               chk("rsp_err", 64'(rsp_err), 64'(r.err));
            end
         end else if (rsp_valid != 3'b000 || rsp_err) begin
            chk("rsp_spurious", 64'({rsp_valid, rsp_err}), 64'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 3'b111;
      req_addr = {64'h3000, 64'h2000, 64'h1000};
      req_wdata = 64'hA5;
      wbuf_full = 1'b0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_tid = '0;

      // Reset state, with requests already pending
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_mem_valid", 64'(mem_req_valid), 64'h0);
      chk("rst_idle", 64'(idle), 64'h1);
      chk("rst_st_cnt", 64'(st_cnt), 64'h0);
      chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Round-robin 0,1,2,0 with TIDs 0..3
      exp_req(0, 0, 0);     step(3'b001);
      exp_req(1, 1, 0);     step(3'b010);
      exp_req(2, 2, 64'hA5); step(3'b100);
      exp_req(0, 3, 0);     step(3'b001);
      req_valid = 3'b000;
      step(3'b000);

      // Back-pressure: payload held for 5 cycles, no new grant
      req_valid = 3'b010;
      mem_req_ready = 1'b0;
      exp_req(1, 4, 0); step(3'b010);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", 64'(req_ready), 64'h0);
         chk("stall_valid", 64'(mem_req_valid), 64'h1);
         chk("stall_tid", 64'(mem_req_tid), 64'h4);
         chk("stall_addr", mem_req_addr, 64'h2000);
         @(posedge clk); #1;
      end
      req_valid = 3'b000;
      mem_req_ready = 1'b1;
      step(3'b000);

      // Responses, store count, bad TID
      @(negedge clk); chk("st_cnt_one", 64'(st_cnt), 64'h1);
      @(posedge clk); #1;
      rsp(1, 3'b010, 1'b0);
      rsp(2, 3'b100, 1'b0);
      @(negedge clk); chk("st_cnt_dec", 64'(st_cnt), 64'h0);
      @(posedge clk); #1;
      rsp(2, 3'b000, 1'b1);
      @(negedge clk);
      chk("err_st_cnt", 64'(st_cnt), 64'h0);
      chk("err_idle", 64'(idle), 64'h0);
      @(posedge clk); #1;
      rsp(0, 3'b001, 1'b0);
      rsp(3, 3'b001, 1'b0);
      rsp(4, 3'b010, 1'b0);
      @(negedge clk); chk("idle_drained", 64'(idle), 64'h1);
      @(posedge clk); #1;

      // Seven stores in flight, then the cap holds stores back
      req_valid = 3'b100;
      for (int i = 0; i < 7; i++) begin
         req_wdata = 64'hD0 + 64'(i);
         exp_req(2, i, 64'hD0 + 64'(i));
         step(3'b100);
      end
      @(negedge clk); chk("st_cnt_full", 64'(st_cnt), 64'h7);
      chk("st_cap_ready", 64'(req_ready), 64'h0);
      @(posedge clk); #1;
      req_valid = 3'b101;
      exp_req(0, 7, 0); step(3'b001);
      req_valid = 3'b111;
      step(3'b000);

      // Freeing a store TID: no grant this cycle, store grant next cycle
      req_valid = 3'b100;
      rsp_q.push_back({3'b100, 1'b0});
      mem_rsp_valid = 1'b1;
      mem_rsp_tid = 3'd3;
      @(negedge clk);
      chk("free_same_cycle_ready", 64'(req_ready), 64'h0);
      chk("free_same_cycle_cnt", 64'(st_cnt), 64'h7);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      req_wdata = 64'hE0;
      exp_req(2, 3, 64'hE0);
      @(negedge clk);
      chk("st_cnt_six", 64'(st_cnt), 64'h6);
      chk("store_regrant", 64'(req_ready), 64'h4);
      @(posedge clk); #1;
      req_valid = 3'b000;
      @(negedge clk); chk("st_cnt_back7", 64'(st_cnt), 64'h7);
      @(posedge clk); #1;

      for (int t = 0; t < 8; t++) rsp(t, (t == 7) ? 3'b001 : 3'b100, 1'b0);
      @(negedge clk);
      chk("drain_st_cnt", 64'(st_cnt), 64'h0);
      chk("drain_idle", 64'(idle), 64'h1);
      @(posedge clk); #1;

      // Write-buffer urgency (rr_ptr is 0 here)
      req_valid = 3'b111;
      wbuf_full = 1'b1;
      req_wdata = 64'hF0;
`ifdef CVA6_MEMARB_WBUF_URGENT_EN
      exp_req(2, 0, 64'hF0); step(3'b100);
      wbuf_full = 1'b0;
      exp_req(0, 1, 0);      step(3'b001);
`else
      exp_req(0, 0, 0);      step(3'b001);
      wbuf_full = 1'b0;
      exp_req(1, 1, 0);      step(3'b010);
`endif
      req_valid = 3'b000;
      step(3'b000);
      step(3'b000);

      // Asynchronous reset mid-transaction
      mem_req_ready = 1'b0;
      req_valid = 3'b001;
      step(3'b001);
      req_valid = 3'b000;
      @(negedge clk);
      chk("pre_rst_valid", 64'(mem_req_valid), 64'h1);
      #2;
      req_valid = 3'b111;
      mem_rsp_valid = 1'b1;
      mem_rsp_tid = 3'd0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(mem_req_valid), 64'h0);
      chk("async_rst_idle", 64'(idle), 64'h1);
      chk("async_rst_ready", 64'(req_ready), 64'h0);
      chk("async_rst_st_cnt", 64'(st_cnt), 64'h0);
      chk("async_rst_rsp", 64'({rsp_valid, rsp_err}), 64'h0);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      req_valid = 3'b010;
      mem_req_ready = 1'b1;
      rst_n = 1'b1;
      exp_req(1, 0, 0); step(3'b010);
      req_valid = 3'b000;
      step(3'b000);
      step(3'b000);

      chk("req_q_empty", 64'(req_q.size()), 64'h0);
      chk("rsp_q_empty", 64'(rsp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wt_mem_req_arbiter.md
WT_MEM_REQ_ARBITER -- requirements
Module: wt_mem_req_arbiter

Interface
REQ-001 SHALL have parameter MEM_TID_WIDTH, default 2: transaction ID width; the ID pool size is 2**MEM_TID_WIDTH.
REQ-002 SHALL have parameter MAX_OUTSTANDING_STORES, default 7: cap on in-flight store transactions.
REQ-003 SHALL have parameter ADDR_WIDTH, default 64: request address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64: store data width.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid_i, input, 3: per-requester request valid; bit0 icache fill, bit1 dcache load miss, bit2 write-buffer store.
REQ-008 SHALL have port req_ready_o, output, 3: per-requester capture acknowledge.
REQ-009 SHALL have port req_addr_i, input, 3*ADDR_WIDTH: per-requester address; requester k occupies slice k.
REQ-010 SHALL have port req_wdata_i, input, DATA_WIDTH: store data, used by requester 2 only.
REQ-011 SHALL have port wbuf_full_i, input, 1: write-buffer-full urgency hint.
REQ-012 SHALL have port mem_req_valid_o, output, 1: memory request valid.
REQ-013 SHALL have port mem_req_ready_i, input, 1: memory request accepted.
REQ-014 SHALL have ports mem_req_addr_o (ADDR_WIDTH), mem_req_wdata_o (DATA_WIDTH), mem_req_we_o (1) and mem_req_tid_o (MEM_TID_WIDTH), all outputs: registered request payload.
REQ-015 SHALL have ports mem_rsp_valid_i (1) and mem_rsp_tid_i (MEM_TID_WIDTH), inputs: memory response.
REQ-016 SHALL have port rsp_valid_o, output, 3: one-hot response routed to the owning requester.
REQ-017 SHALL have port rsp_err_o, output, 1: pulse on a response carrying an unallocated TID.
REQ-018 SHALL have port st_cnt_o, output, $clog2(MAX_OUTSTANDING_STORES+1): in-flight store count.
REQ-019 SHALL have port idle_o, output, 1: high when no TID is allocated and mem_req_valid_o=0.

Function
REQ-020 Output slot SHALL be free when mem_req_valid_o=0, or when mem_req_valid_o=1 and mem_req_ready_i=1 in the same cycle.
- When the slot is free, one eligible requester SHALL be captured into the output register.
REQ-021 A requester SHALL be eligible when all of the following hold:
- its req_valid_i bit is 1;
- at least one TID is free;
- for requester 2 only, st_cnt_o < MAX_OUTSTANDING_STORES.
REQ-022 Winner selection SHALL be round-robin:
- search starts at rr_ptr;
- rr_ptr becomes winner+1 mod 3 after each capture.
REQ-023 req_ready_o SHALL be one-hot to the captured winner, combinational in the capture cycle, and zero otherwise.
REQ-024 mem_req_valid_o SHALL rise in the cycle after capture.
- Payload SHALL stay stable until mem_req_ready_i=1; no retraction.
REQ-025 The captured request SHALL be allocated the lowest-index free TID.
- mem_req_we_o SHALL be 1 for requester 2 and 0 otherwise.
REQ-026 A per-TID owner table SHALL record the source requester at capture.
REQ-027 On mem_rsp_valid_i with an allocated TID:
- rsp_valid_o[owner] SHALL pulse in the same cycle (combinational);
- the TID SHALL be freed at the clock edge and be reusable from the next cycle only.
REQ-028 On mem_rsp_valid_i with an unallocated TID: rsp_err_o SHALL pulse and all state SHALL be unchanged.
REQ-029 st_cnt_o SHALL:
- increment on store capture;
- decrement on a response for a store-owned TID;
- stay unchanged when both occur in the same cycle.
REQ-030 With all TIDs allocated, req_ready_o SHALL be 0 until a freeing response has been registered.

Reset
REQ-031 Asserting rst_ni=0 SHALL immediately, asynchronously and including mid-transaction, force:
- req_ready_o, mem_req_valid_o, rsp_valid_o, rsp_err_o and st_cnt_o to 0;
- idle_o to 1;
- all TIDs free, rr_ptr to 0, and owner table contents to don't-care.

Configuration
REQ-032 With macro CVA6_MEMARB_WBUF_URGENT_EN defined:
- when wbuf_full_i=1 and requester 2 is eligible, requester 2 SHALL win regardless of rr_ptr;
- rr_ptr SHALL be unchanged by that capture.
REQ-033 Without CVA6_MEMARB_WBUF_URGENT_EN, wbuf_full_i SHALL be ignored and arbitration SHALL be pure round-robin.

Verification
REQ-034 Scenario: after reset, all three requesters held valid, mem_req_ready_i=1 -> grants 0,1,2,0 with TIDs 0,1,2,3; then stall.
REQ-035 Scenario: mem_req_ready_i=0 for 5 cycles after a grant -> payload and TID stable, no new grant, req_ready_o=0.
REQ-036 Scenario: 7 stores in flight, store request pending -> no store grant; a store response -> st_cnt_o 7->6 and a store grant the next cycle.
REQ-037 Scenario: mem_rsp_tid_i=2 while TID 2 is free -> rsp_err_o=1, st_cnt_o unchanged.
REQ-038 Scenario: CVA6_MEMARB_WBUF_URGENT_EN defined, rr_ptr=0, all valid, wbuf_full_i=1 -> requester 2 granted, rr_ptr stays 0.
REQ-039 Scenario: rst_ni=0 asserted while mem_req_valid_o=1 -> mem_req_valid_o=0 without a clock edge, idle_o=1.
